pll_drp_reconfig: RTL

PLL_DRP_RECONFIG -- requirements
Module: pll_drp_reconfig

---
 rtl/pll_drp_pkg.sv | 27 ++
 rtl/drp_timeout_cnt.sv | 27 ++
 rtl/pll_drp_reconfig.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_drp_pkg.sv
// rtl/pll_drp_pkg.sv - shared types and constants for the PLL DRP reconfiguration block
package pll_drp_pkg;

  localparam int unsigned DRP_AW = 7;
  localparam int unsigned DRP_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_READ,
    ST_WAIT_RD,
    ST_WRITE,
    ST_WAIT_WR,
    ST_ACCEPT,
    ST_WAIT_LOCK
  } state_e;

  // Mask bit 1 keeps the bit read back from the PLL, 0 takes it from the command.
  function automatic logic [DRP_DW-1:0] drp_merge(
    input logic [DRP_DW-1:0] rd,
    input logic [DRP_DW-1:0] mask,
    input logic [DRP_DW-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/drp_timeout_cnt.sv
// rtl/drp_timeout_cnt.sv - loadable saturating down-counter with expired flag
module drp_timeout_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pll_drp_reconfig.sv
// rtl/pll_drp_reconfig.sv - read-modify-write PLL DRP sequencer with reset hold and lock wait
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_FILTER  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DRP_AW-1:0] cmd_addr,
  input  logic [DRP_DW-1:0] cmd_mask,
  input  logic [DRP_DW-1:0] cmd_data,
  input  logic              cmd_last,
  output logic [DRP_AW-1:0] drp_addr,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  output logic              drp_en,
  output logic              drp_we,
  input  logic              drp_rdy,
  output logic              pll_rst,
  input  logic              pll_locked,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned DRDY_W = $clog2(DRDY_TIMEOUT);
  localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT);

  // Counters load as the access/lock wait begins, so these offsets land done
  // exactly DRDY_TIMEOUT cycles after drp_en and LOCK_TIMEOUT cycles after pll_rst falls.
  localparam logic [DRDY_W-1:0] DRDY_LOAD = DRDY_W'(DRDY_TIMEOUT - 2);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_TIMEOUT - 1);

  state_e              state_q;
  logic [DRP_AW-1:0]   addr_q;
  logic [DRP_DW-1:0]   mask_q;
  logic [DRP_DW-1:0]   data_q;
  logic                last_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [FILT_W-1:0]   filt_q;
  logic                pll_rst_q, drp_en_q, drp_we_q, done_q, err_q, busy_q, cmd_ready_q;
  logic [DRP_AW-1:0]   drp_addr_q;
  logic [DRP_DW-1:0]   drp_di_q;

  logic cmd_fire;
  logic drdy_load, drdy_dec, drdy_expired;
  logic lock_load, lock_dec, lock_expired;

  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign drdy_load = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign drdy_dec  = (state_q == ST_WAIT_RD) || (state_q == ST_WAIT_WR);
  assign lock_load = (state_q == ST_WAIT_WR) && drp_rdy && last_q;
  assign lock_dec  = (state_q == ST_WAIT_LOCK);

  drp_timeout_cnt #(.W(DRDY_W)) u_drdy_tmo (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (drdy_load),
    .load_val_i (DRDY_LOAD),
    .dec_i      (drdy_dec),
    .expired_o  (drdy_expired)
  );

  drp_timeout_cnt #(.W(LOCK_W)) u_lock_tmo (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lock_load),
    .load_val_i (LOCK_LOAD),
    .dec_i      (lock_dec),
    .expired_o  (lock_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      hold_q      <= '0;
      filt_q      <= '0;
      pll_rst_q   <= 1'b0;
      drp_en_q    <= 1'b0;
      drp_we_q    <= 1'b0;
      drp_addr_q  <= '0;
      drp_di_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      drp_en_q <= 1'b0;
      drp_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            addr_q      <= cmd_addr;
            mask_q      <= cmd_mask;
            data_q      <= cmd_data;
            last_q      <= cmd_last;
            hold_q      <= HOLD_W'(RST_HOLD - 1);
            pll_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            drp_en_q   <= 1'b1;
            drp_addr_q <= addr_q;
            state_q    <= ST_READ;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_READ: state_q <= ST_WAIT_RD;
        ST_WAIT_RD: begin
          if (drp_rdy) begin
            drp_di_q <= drp_merge(drp_do, mask_q, data_q);
            drp_en_q <= 1'b1;
            drp_we_q <= 1'b1;
            state_q  <= ST_WRITE;
          end else if (drdy_expired) begin
            pll_rst_q   <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_WRITE: state_q <= ST_WAIT_WR;
        ST_WAIT_WR: begin
          if (drp_rdy) begin
            if (last_q) begin
              pll_rst_q <= 1'b0;
              filt_q    <= '0;
              state_q   <= ST_WAIT_LOCK;
            end else begin
              cmd_ready_q <= 1'b1;
              state_q     <= ST_ACCEPT;
            end
          end else if (drdy_expired) begin
            pll_rst_q   <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          if (cmd_fire) begin
            addr_q      <= cmd_addr;
            mask_q      <= cmd_mask;
            data_q      <= cmd_data;
            last_q      <= cmd_last;
            drp_en_q    <= 1'b1;
            drp_addr_q  <= cmd_addr;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_READ;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock completing on the timeout cycle still counts as success.
          if (pll_locked && (filt_q == FILT_W'(LOCK_FILTER - 1))) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (lock_expired) begin
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            filt_q <= pll_locked ? filt_q + 1'b1 : '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign drp_addr  = drp_addr_q;
  assign drp_di    = drp_di_q;
  assign drp_en    = drp_en_q;
  assign drp_we    = drp_we_q;
  assign pll_rst   = pll_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
